spi_target_regs: RTL and testbench

// SPI target (responder) for the SPI master inside rfid_top: lets an external controller (or a

---
 rtl/spi_target_regs_pkg.sv | 14 +
 rtl/spi_target_regs_if.sv | 27 ++
 rtl/spi_target_regs_sync_edge.sv | 33 +++
 rtl/spi_target_regs.sv | 154 +++++++++++++++
 tb/tb_spi_target_regs.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_regs_pkg.sv
// Shared types and constants for the SPI target register block.
// FSM encoding and command byte field positions.
package spi_target_regs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  localparam int SPI_RW_BIT   = 7;
  localparam int SPI_ADDR_MSB = 6;

endpackage

// File: rtl/spi_target_regs_if.sv
// SPI pad bundle between an SPI master and the register target.
// Mode 0, MSB first; cs_n is active-low.
interface spi_target_regs_if;

  logic sck;
  logic mosi;
  logic cs_n;
  logic miso;
  logic miso_oe;

  modport master (
    output sck,
    output mosi,
    output cs_n,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sck,
    input  mosi,
    input  cs_n,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/spi_target_regs_sync_edge.sv
// Synchronizer chain with a registered edge pulse.
// Direction of the edge is the current synced level.
module spi_target_regs_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_edge <= r_sync[STAGES-1] ^ r_prev;
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_edge = r_edge;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target exposing an 8-bit register file.
// Frame: {rw, addr} command byte, then auto-incrementing data bytes.
module spi_target_regs
  import spi_target_regs_pkg::*;
#(
  parameter int         ADDR_W      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  spi_target_regs_if.slave          spi,
  output logic [8*(2**ADDR_W)-1:0]  o_reg_q,
  output logic                      o_wr_strobe,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic                      o_busy
);

  localparam int N = 2**ADDR_W;

  spi_state_t        r_state;
  spi_state_t        w_state_nx;
  logic [2:0]        r_cnt;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_regs [N];
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_miso;
  logic              r_oe;
  logic [SYNC_STAGES-1:0] r_mosi;

  logic w_sck_q, w_sck_edge;
  logic w_cs_q, w_cs_edge;
  logic w_sck_rise, w_sck_fall, w_cs_fall;
  logic w_byte_done, w_rd_act;
  logic [7:0] w_byte;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [8*N-1:0] w_flat;

  spi_target_regs_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (spi.sck),
    .o_q    (w_sck_q),
    .o_edge (w_sck_edge)
  );

  spi_target_regs_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (spi.cs_n),
    .o_q    (w_cs_q),
    .o_edge (w_cs_edge)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mosi <= '0;
    else          r_mosi <= {r_mosi[SYNC_STAGES-2:0], spi.mosi};
  end

  assign w_sck_rise  = w_sck_edge & w_sck_q;
  assign w_sck_fall  = w_sck_edge & ~w_sck_q;
  assign w_cs_fall   = w_cs_edge & ~w_cs_q;
  assign w_byte      = {r_rx, r_mosi[SYNC_STAGES-1]};
  assign w_byte_done = w_sck_rise && (r_cnt == 3'd7);
  assign w_addr_inc  = r_addr + 1'b1;

  genvar g;
  for (g = 0; g < N; g++) begin : g_flat
    if (g == 0) begin : g_id
      assign w_flat[7:0] = ID_VALUE;
    end else begin : g_reg
      assign w_flat[8*g +: 8] = r_regs[g];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_state_nx = CMD;
      CMD:     if (w_byte_done) w_state_nx = DATA;
      DATA:    w_state_nx = DATA;
      default: w_state_nx = IDLE;
    endcase
    if (w_cs_q) w_state_nx = IDLE;
  end

  assign w_rd_act = (r_state == DATA) && (w_state_nx == DATA) && r_rw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_wr_strobe <= 1'b0;
      r_oe        <= w_rd_act;
      if (w_state_nx == IDLE || r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_sck_rise) begin
        r_cnt <= r_cnt + 3'd1;
        r_rx  <= w_byte[6:0];
        if (r_cnt == 3'd7) begin
          if (r_state == CMD) begin
            r_rw   <= w_byte[SPI_RW_BIT];
            r_addr <= w_byte[ADDR_W-1:0];
            r_tx   <= w_flat[{w_byte[ADDR_W-1:0], 3'b000} +: 8];
          end else begin
            if (!r_rw && r_addr != '0) begin
              r_regs[r_addr] <= w_byte;
              r_wr_strobe    <= 1'b1;
              r_wr_addr      <= r_addr;
            end
            r_addr <= w_addr_inc;
            r_tx   <= w_flat[{w_addr_inc, 3'b000} +: 8];
          end
        end
      end
      // miso is forced low outside an active read so the pad never floats a stale bit
      if (!w_rd_act) begin
        r_miso <= 1'b0;
      end else if (w_sck_fall) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign o_reg_q     = w_flat;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_busy      = ~w_cs_q;
  assign spi.miso    = r_miso;
  assign spi.miso_oe = r_oe;

endmodule

// File: tb/tb_spi_target_regs.sv
// Randomized bench for spi_target_regs against a frame-level register model.
// Model tracks register contents, expected writes and read data per byte.
module tb_spi_target_regs;

  localparam int AW   = 4;
  localparam int N    = 16;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*N-1:0] reg_q;
  logic wr_strobe;
  logic [AW-1:0] wr_addr;
  logic busy;

  spi_target_regs_if spi ();

  spi_target_regs #(
    .ADDR_W     (AW),
    .SYNC_STAGES(2),
    .ID_VALUE   (8'hA5)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .spi        (spi),
    .o_reg_q    (reg_q),
    .o_wr_strobe(wr_strobe),
    .o_wr_addr  (wr_addr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [N];
  logic [AW-1:0] last_wa;
  int q_a[$];
  logic [7:0] q_d[$];
  int strobes = 0;
  bit quiet = 1'b0;
  bit prev_strobe = 1'b0;
  logic [7:0] txb [8];
  logic [7:0] rxb [8];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 30)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mrd(input int a);
    return (a == 0) ? 8'hA5 : model[a];
  endfunction

  function automatic logic [8*N-1:0] mflat();
    logic [8*N-1:0] f;
    for (int i = 0; i < N; i++) f[8*i +: 8] = mrd(i);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 8'h00;
    last_wa = '0;
    q_a.delete();
    q_d.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (wr_strobe) begin
        strobes++;
        check("strobe_width", prev_strobe, 1'b0);
        if (q_a.size() == 0) begin
          check("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          int a;
          logic [7:0] d;
          a = q_a.pop_front();
          d = q_d.pop_front();
          check("wr_addr", wr_addr, a);
          check("wr_data", reg_q[8*a +: 8], d);
        end
      end
      prev_strobe = wr_strobe;
      if (quiet) begin
        check("idle_regs", reg_q, mflat());
        check("idle_outs", {busy, spi.miso_oe, spi.miso, wr_strobe, wr_addr},
              {4'b0000, last_wa});
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nb,
                           input logic exp_oe, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi.mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      spi.sck = 1'b1;
      r = {r[6:0], spi.miso};
      check("oe_at_rise", spi.miso_oe, exp_oe);
      check("busy_at_rise", busy, 1'b1);
      repeat (HALF) @(negedge clk);
      spi.sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int tail);
    logic rw;
    int a;
    logic [7:0] exp, dummy;
    rw = cmd[7];
    a  = int'(cmd[3:0]);
    quiet = 1'b0;
    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(cmd, 8, 1'b0, dummy);
    for (int k = 0; k < nbytes; k++) begin
      exp = mrd(a);
      if (!rw && a != 0) begin
        model[a] = txb[k];
        last_wa = AW'(a);
        q_a.push_back(a);
        q_d.push_back(txb[k]);
      end
      send_bits(txb[k], 8, rw, rxb[k]);
      if (rw) check("rd_byte", rxb[k], exp);
      a = (a + 1) % N;
    end
    if (tail > 0) send_bits(txb[nbytes], tail, rw, dummy);
    repeat (HALF) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (12) @(negedge clk);
    quiet = 1'b1;
  endtask

  task automatic rand_frames(input int n);
    for (int f = 0; f < n; f++) begin
      logic [7:0] cmd;
      int nb, tl;
      cmd = 8'($urandom);
      nb  = $urandom_range(0, 4);
      tl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 8; k++) txb[k] = 8'($urandom);
      spi_frame(cmd, nb, tl);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    logic [7:0] dummy;
    spi.sck  = 1'b0;
    spi.mosi = 1'b0;
    spi.cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_regs", reg_q, {120'h0, 8'hA5});
    check("rst_outs", {busy, spi.miso_oe, spi.miso, wr_strobe, wr_addr}, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    quiet = 1'b1;

    s0 = strobes;
    txb[0] = 8'h5C;
    spi_frame(8'h03, 1, 0);
    check("lit_reg3", reg_q[31:24], 8'h5C);
    check("lit_wr_addr3", wr_addr, 4'd3);
    check("lit_one_strobe", strobes - s0, 1);

    s0 = strobes;
    txb[0] = 8'h11;
    txb[1] = 8'h22;
    spi_frame(8'h0F, 2, 0);
    check("lit_reg15", reg_q[127:120], 8'h11);
    check("lit_reg0_burst", reg_q[7:0], 8'hA5);
    check("lit_burst_strobes", strobes - s0, 1);

    txb[0] = 8'h00;
    txb[1] = 8'hFF;
    spi_frame(8'h83, 2, 0);
    check("lit_rd_reg3", rxb[0], 8'h5C);
    check("lit_rd_reg4", rxb[1], 8'h00);

    spi_frame(8'h80, 1, 0);
    check("lit_rd_id", rxb[0], 8'hA5);
    s0 = strobes;
    txb[0] = 8'hFF;
    spi_frame(8'h00, 1, 0);
    check("lit_id_nostrobe", strobes - s0, 0);
    check("lit_id_kept", reg_q[7:0], 8'hA5);

    s0 = strobes;
    txb[0] = 8'hFF;
    spi_frame(8'h02, 0, 5);
    check("lit_abort_nostrobe", strobes - s0, 0);
    check("lit_abort_reg2", reg_q[23:16], 8'h00);
    check("lit_abort_busy", busy, 1'b0);
    txb[0] = 8'h3C;
    spi_frame(8'h02, 1, 0);
    check("lit_after_abort", reg_q[23:16], 8'h3C);

    rand_frames(30);

    quiet = 1'b0;
    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(8'h05, 8, 1'b0, dummy);
    send_bits(8'hE7, 3, 1'b0, dummy);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_regs", reg_q, {120'h0, 8'hA5});
    check("midrst_outs", {busy, spi.miso_oe, spi.miso, wr_strobe, wr_addr}, 8'h00);
    spi.cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    quiet = 1'b1;

    rand_frames(12);
    check("pending_writes", q_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
